muldiv_ctl: RTL
===============

# muldiv_ctl

Multi-cycle multiply/divide sequencer for the pipelined MIPS execute stage. It implements MULT, MULTU, DIV and DIVU, and owns the architectural HI/LO registers. It accepts one operation per start pulse using the execute-stage bypassed operands, iterates for a fixed number of cycles, and raises a stall request while a HI/LO consumer sits in decode. The pipeline hazard logic ORs its stall output into AnyStall.

## Interface
- W, 32: operand width; the iteration count equals W.
- clk  in  1  pipeline clock
- reset  in  1  synchronous, active-high; one clock, all state is clocked by clk
- start  in  1  a valid mul/div op is in EX and not stalled this cycle
- op  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- a  in  W  bypassed rs operand (multiplicand / dividend)
- b  in  W  bypassed rt operand (multiplier / divisor)
- kill  in  1  flush of the EX op; aborts an in-flight operation
- mthi, mtlo  in  1  write HI / LO from wdata (EX stage, non-stalled)
- wdata  in  W  MTHI/MTLO data
- hilo_use  in  1  instruction in ID reads or writes HI/LO, or is a mul/div
- busy  out  1  operation in flight
- done  out  1  one-cycle pulse: HI/LO just updated by a completed op
- Stall_MD  out  1  stall request to the hazard unit
- hi, lo  out  W  architectural HI/LO

## Operation
- States: IDLE, ITER, FIX.
  - IDLE -> ITER on start & !kill.
  - ITER -> FIX after W iterations (cnt reaches W-1).
  - FIX -> IDLE, writing HI/LO.
- At start, latch op and the operand magnitudes. For signed ops take |a| and |b|; latch neg_q = sign(a)^sign(b) and neg_r = sign(a). Unsigned ops: both flags 0.
- MUL ITER: unsigned shift-add over a 2W-bit accumulator, one multiplier bit per cycle.
- FIX for MUL: if neg_q, negate the 2W result. hi = upper W bits, lo = lower W bits.
- DIV ITER: restoring division, one quotient bit per cycle. Remainder is W+1 bits wide.
- FIX for DIV:
  - lo = quotient, negated if neg_q.
  - hi = remainder, negated if neg_r.
- Division by zero (b == 0, any signedness): lo = all ones, hi = a as received. This takes full latency with no early exit.
- 0x80000000 / -1 gives lo = 0x80000000, hi = 0. No trap.
- Arithmetic is modulo 2^W per half. Magnitude of 0x80000000 is 2^31, held in W+1 bits.
- kill while busy: go to IDLE next edge; HI/LO unchanged; no done.
- kill with start in the same cycle: the op is not started.
- start while busy is ignored; it cannot occur legally because Stall_MD holds it.
- mthi/mtlo while IDLE and !start: write at the next edge. Both may assert in the same cycle.
- mthi/mtlo together with start or busy: dropped, since the stall prevents this legally.
- A FIX write takes precedence over everything except reset.
- Stall_MD = (busy | (start & !kill)) & hilo_use.

## Timing
- Cycle 0: start = 1, sampled at the end of cycle 0.
- Cycles 1..W: busy = 1, ITER.
- Cycle W+1: FIX, busy = 1. HI/LO written at the end of the cycle.
- Cycle W+2: busy = 0, done = 1, new hi/lo visible. A new start is accepted in this cycle.
- Total latency from start to result visible is W+2 cycles (34 for W = 32).
- Stall_MD is combinational and can assert in cycle 0. It deasserts in cycle W+2, so the consumer in ID reads the new HI/LO through a same-cycle bypass: hi/lo are register outputs already updated.
- Reset values: state IDLE, busy 0, done 0, hi 0, lo 0, Stall_MD 0 (with hilo_use low), cnt 0.
- Reset mid-operation: IDLE at the next edge; HI/LO cleared.

## Structure
- Shared package muldiv_pkg: op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU) and the state enum (IDLE/ITER/FIX). The ALU decoder also uses the op codes.
- One sub-module, muldiv_step: the combinational single-iteration datapath. It takes accumulator/remainder, operand and mode, and returns the next accumulator plus quotient bit.
- muldiv_ctl holds the FSM, the counter, sign handling, and the HI/LO registers.

## Test plan
- MULT a=0xFFFFFFFD (-3), b=7 -> busy cycles 1..33; cycle 34 done=1, hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Then DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=0x12345678, b=0 -> lo=0xFFFFFFFF, hi=0x12345678 at cycle 34. Then DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI 0xAAAA0000 and MTLO 0x5555 in the same cycle while idle -> next cycle hi=0xAAAA0000, lo=0x5555. Start MULT, then kill at cycle 10 -> busy=0 at cycle 11, hi/lo unchanged, no done.
- hilo_use held high from cycle 0 with start -> Stall_MD=1 for cycles 0..33, 0 at cycle 34. With hilo_use low, Stall_MD stays 0 throughout.
- Assert reset at cycle 20 of a DIV -> cycle 21: busy=0, hi=lo=0, done never pulses. A start in cycle 22 completes normally.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings (also used by
// the ALU decoder) and the sequencer state codes.
package muldiv_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t ITER = 2'd1;
  localparam state_t FIX  = 2'd2;

endpackage

// File: rtl/muldiv_if.sv
// Execute-stage connection to the multiply/divide sequencer: op issue, MTHI/MTLO,
// hazard handshake and the architectural HI/LO outputs.
interface muldiv_if #(
  parameter int W = 32
);

  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         kill;
  logic         mthi;
  logic         mtlo;
  logic [W-1:0] wdata;
  logic         hilo_use;
  logic         busy;
  logic         done;
  logic         Stall_MD;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  modport master (
    output start, op, a, b, kill, mthi, mtlo, wdata, hilo_use,
    input  busy, done, Stall_MD, hi, lo
  );

  modport slave (
    input  start, op, a, b, kill, mthi, mtlo, wdata, hilo_use,
    output busy, done, Stall_MD, hi, lo
  );

endinterface

// File: rtl/muldiv_step.sv
// One iteration of the unsigned datapath: a shift-add multiply step or a
// restoring-division step over a {upper W+1 bits, lower W bits} accumulator.
module muldiv_step import muldiv_pkg::*; #(
  parameter int W = 32
) (
  input  logic [2*W:0] acc,
  input  logic [W-1:0] operand,
  input  logic         isDiv,
  output logic [2*W:0] accNext,
  output logic         qBit
);

  logic [W:0]   mulSum;
  logic [W:0]   shifted;
  logic [W+1:0] trial;

  // The divide step leaves bit 0 clear; the caller merges qBit into it.
  always_comb begin
    mulSum  = acc[2*W:W] + (acc[0] ? {1'b0, operand} : '0);
    shifted = {acc[2*W-1:W], acc[W-1]};
    trial   = {1'b0, shifted} - {2'b00, operand};
    qBit    = 1'b0;
    accNext = acc;
    if (isDiv) begin
      qBit    = ~trial[W+1];
      accNext = {(qBit ? trial[W:0] : shifted), acc[W-2:0], 1'b0};
    end else begin
      accNext = {1'b0, mulSum, acc[W-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_ctl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning HI/LO; iterates on operand
// magnitudes and applies signs in a final fix-up cycle.
module muldiv_ctl import muldiv_pkg::*; #(
  parameter int W = 32
) (
  input  logic     clk,
  input  logic     reset,
  muldiv_if.slave  bus
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2*W:0]  acc;
  logic [W-1:0]  operand;
  logic          isDivReg;
  logic          negQ;
  logic          negR;
  logic          divZero;
  logic [W-1:0]  hiReg;
  logic [W-1:0]  loReg;
  logic          doneReg;

  logic          isSignedOp;
  logic          isDivOp;
  logic          signA;
  logic          signB;
  logic [W-1:0]  magA;
  logic [W-1:0]  magB;
  logic          accept;
  logic          busy;

  logic [2*W:0]   stepAcc;
  logic           stepQ;
  logic [2*W-1:0] product;
  logic [2*W-1:0] mulRes;
  logic [W-1:0]   quot;
  logic [W-1:0]   rem;
  logic [W-1:0]   resHi;
  logic [W-1:0]   resLo;

  // The magnitude of the most negative value is 2^(W-1), which still fits
  // in W unsigned bits, so the iteration datapath stays unsigned W-bit.
  always_comb begin
    isSignedOp = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    isDivOp    = (bus.op == OP_DIV)  || (bus.op == OP_DIVU);
    signA      = isSignedOp & bus.a[W-1];
    signB      = isSignedOp & bus.b[W-1];
    magA       = signA ? ((~bus.a) + W'(1)) : bus.a;
    magB       = signB ? ((~bus.b) + W'(1)) : bus.b;
    accept     = (state == IDLE) && bus.start && !bus.kill;
    busy       = (state != IDLE);
  end

  muldiv_step #(.W(W)) step (
    .acc     (acc),
    .operand (operand),
    .isDiv   (isDivReg),
    .accNext (stepAcc),
    .qBit    (stepQ)
  );

  // Division by zero overrides only LO: the remainder path already yields the
  // raw dividend once its sign is reapplied.
  always_comb begin
    product = acc[2*W-1:0];
    mulRes  = negQ ? ((~product) + (2*W)'(1)) : product;
    quot    = acc[W-1:0];
    rem     = acc[2*W-1:W];
    if (isDivReg) begin
      resLo = divZero ? '1 : (negQ ? ((~quot) + W'(1)) : quot);
      resHi = negR ? ((~rem) + W'(1)) : rem;
    end else begin
      resLo = mulRes[W-1:0];
      resHi = mulRes[2*W-1:W];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      acc      <= '0;
      operand  <= '0;
      isDivReg <= 1'b0;
      negQ     <= 1'b0;
      negR     <= 1'b0;
      divZero  <= 1'b0;
      hiReg    <= '0;
      loReg    <= '0;
      doneReg  <= 1'b0;
    end else begin
      doneReg <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state    <= ITER;
            cnt      <= '0;
            isDivReg <= isDivOp;
            negQ     <= signA ^ signB;
            negR     <= signA;
            divZero  <= isDivOp && (bus.b == '0);
            operand  <= isDivOp ? magB : magA;
            acc      <= {{(W+1){1'b0}}, (isDivOp ? magA : magB)};
          end else if (!bus.start) begin
            if (bus.mthi) hiReg <= bus.wdata;
            if (bus.mtlo) loReg <= bus.wdata;
          end
        end
        ITER: begin
          if (bus.kill) begin
            state <= IDLE;
          end else begin
            acc <= stepAcc | {{(2*W){1'b0}}, stepQ};
            cnt <= cnt + 1'b1;
            if (cnt == CW'(W-1)) state <= FIX;
          end
        end
        FIX: begin
          state   <= IDLE;
          hiReg   <= resHi;
          loReg   <= resLo;
          doneReg <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy     = busy;
  assign bus.done     = doneReg;
  assign bus.hi       = hiReg;
  assign bus.lo       = loReg;
  assign bus.Stall_MD = (busy | (bus.start & ~bus.kill)) & bus.hilo_use;

endmodule
